// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [3:0]  XFER_BYTE = 4'd1;
    localparam logic [3:0]  XFER_HALF = 4'd2;
    localparam logic [15:0] ADDR_MAX  = 16'hFFFF;

    // Request fields captured on the accept edge.
    typedef struct packed {
        logic        write;
        logic        half;
        logic        sgn;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

endpackage

// File: rtl/lsu_load_ext.sv
// Builds the 16-bit load result from captured low/high bytes (sign/zero extend bytes).
// Latency: purely combinational.
// Backpressure: none; caller holds inputs stable while the result is consumed.
module lsu_load_ext (
    input  logic [7:0]  lo_byte,
    input  logic [7:0]  hi_byte,
    input  logic        half,
    input  logic        is_signed,
    output logic [15:0] ext_data
);

    // Halfwords pass through; bytes replicate bit 7 only for signed loads.
    always_comb begin
        if (half) begin
            ext_data = {hi_byte, lo_byte};
        end else begin
            ext_data = {{8{is_signed & lo_byte[7]}}, lo_byte};
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller feeding a 16-bit little-endian byte-addressed memory; optional LSU_MISALIGN_SPLIT_EN splits odd halfwords.
// Latency: accept to resp_valid is 2 cycles aligned, 3 cycles split, 1 cycle fault.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_half,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_xfer_size,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_ACC0 = ACC0;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] ST_ACC1 = ACC1;
`endif
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]  state_q;
    req_t        req_q;
    logic        fault_q;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;
    logic        odd_half;
    logic        wrap_half;
    logic        req_is_fault;
    logic        split_cur;
    logic [15:0] ext_data;

    assign odd_half  = req_half && req_addr[0];
    assign wrap_half = req_half && (req_addr == ADDR_MAX);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic split_q;
    assign req_is_fault = wrap_half;
    assign split_cur    = split_q;

    // Remember whether the accepted halfword needs two byte accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_q <= 1'b0;
        end else if (state_q == ST_IDLE && req_valid) begin
            split_q <= odd_half && !wrap_half;
        end
    end
`else
    // 0xFFFF is odd, so the odd-halfword check already covers the wrap case.
    assign req_is_fault = odd_half;
    assign split_cur    = 1'b0;
`endif

    // Main sequencer: latch request, step through accesses, hold response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            fault_q <= 1'b0;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q.write <= req_write;
                        req_q.half  <= req_half;
                        req_q.sgn   <= req_signed;
                        req_q.addr  <= req_addr;
                        req_q.wdata <= req_wdata;
                        fault_q     <= req_is_fault;
                        state_q     <= req_is_fault ? ST_RESP : ST_ACC0;
                    end
                end
                ST_ACC0: begin
                    // A split access overwrites hi_q in ACC1.
                    lo_q <= mem_read_data[7:0];
                    hi_q <= mem_read_data[15:8];
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_q <= split_cur ? ST_ACC1 : ST_RESP;
`else
                    state_q <= ST_RESP;
`endif
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ST_ACC1: begin
                    hi_q    <= mem_read_data[7:0];
                    state_q <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (resp_ready) begin
                        fault_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory port: driven only during access states, parked at reset values otherwise.
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_xfer_size    = XFER_BYTE;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        if (state_q == ST_ACC0) begin
            mem_address      = req_q.addr;
            mem_write_enable = req_q.write;
            mem_read_enable  = !req_q.write;
            if (req_q.half && !split_cur) begin
                mem_xfer_size  = XFER_HALF;
                mem_write_data = req_q.wdata;
            end else begin
                mem_write_data = {8'h00, req_q.wdata[7:0]};
            end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        else if (state_q == ST_ACC1) begin
            mem_address      = req_q.addr + 16'd1;
            mem_write_enable = req_q.write;
            mem_read_enable  = !req_q.write;
            mem_write_data   = {8'h00, req_q.wdata[15:8]};
        end
`endif
    end

    lsu_load_ext u_load_ext (
        .lo_byte   (lo_q),
        .hi_byte   (hi_q),
        .half      (req_q.half),
        .is_signed (req_q.sgn),
        .ext_data  (ext_data)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_fault = fault_q;
    assign resp_rdata = (resp_valid && !fault_q && !req_q.write) ? ext_data : '0;

endmodule
